pc_ir_fetch: RTL and testbench

Program-counter and instruction-register responder for the SISC datapath. It is the receiving end of the control FSM's fetch and branch signals (`ir_load`, `pc_write`, `pc_sel`, `br_sel`, `pc_rst`). It runs the instruction-memory read handshake, latches the fetched word into the IR, and computes and applies absolute or relative branch targets. It also returns `busy` so the FSM can hold its fetch state while memory is slow.

---
 rtl/sisc_pkg.sv | 34 +++
 rtl/branch_target.sv | 21 ++
 rtl/pc_ir_fetch.sv | 140 ++++++++++++++
 tb/tb_pc_ir_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: instruction field layout, datapath widths, opcodes
// and the fetch-unit state encoding.
package sisc_pkg;

  localparam int unsigned SISC_PC_W    = 16;
  localparam int unsigned SISC_INSTR_W = 32;
  localparam int unsigned SISC_IMM_W   = 16;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned MM_MSB  = 27;
  localparam int unsigned MM_LSB  = 24;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [3:0] {
    NOOP   = 4'h0,
    LOD    = 4'h1,
    STR    = 4'h2,
    SWP    = 4'h3,
    BRA    = 4'h4,
    BRR    = 4'h5,
    BNE    = 4'h6,
    BNR    = 4'h7,
    ALU_OP = 4'h8,
    HLT    = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/branch_target.sv
// Branch target: absolute (zero-extended imm) or PC-relative (sign-extended imm),
// both wrapping modulo 2^PC_W.
module branch_target
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W = SISC_PC_W
) (
  input  logic [PC_W-1:0]       pc,
  input  logic [SISC_IMM_W-1:0] imm,
  input  logic                  br_sel,
  output logic [PC_W-1:0]       target
);

  logic [PC_W-1:0] imm_zx;
  logic [PC_W-1:0] imm_sx;

  assign imm_zx = PC_W'(imm);
  assign imm_sx = PC_W'($signed(imm));
  assign target = br_sel ? imm_zx : (pc + imm_sx);

endmodule

// File: rtl/pc_ir_fetch.sv
// PC / IR responder for the SISC control FSM: runs the instruction-memory read
// handshake with timeout, latches the IR and applies PC increments and branches.
module pc_ir_fetch
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W     = SISC_PC_W,
  parameter int unsigned INSTR_W  = SISC_INSTR_W,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_rst,
  input  logic                  ir_load,
  input  logic                  pc_write,
  input  logic                  pc_sel,
  input  logic                  br_sel,
  input  logic [INSTR_W-1:0]    mem_rdata,
  input  logic                  mem_valid,
  output logic                  mem_req,
  output logic [PC_W-1:0]       mem_addr,
  output logic [PC_W-1:0]       pc,
  output logic [INSTR_W-1:0]    ir,
  output logic [3:0]            opcode,
  output logic [3:0]            mm,
  output logic [SISC_IMM_W-1:0] imm,
  output logic                  busy,
  output logic                  ir_valid,
  output logic                  fetch_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_MISS = CNT_W'(MAX_WAIT - 1);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               irv_q, irv_d;
  logic               err_q, err_d;
  logic [PC_W-1:0]    br_target;

  branch_target #(.PC_W(PC_W)) u_branch_target (
    .pc     (pc_q),
    .imm    (ir_q[IMM_MSB:IMM_LSB]),
    .br_sel (br_sel),
    .target (br_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Timeout exit fires on the miss that brings the count to MAX_WAIT.
  always_comb begin
    state_d = state_q;
    if (pc_rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ir_load) state_d = ST_WAIT;
        ST_WAIT: if (mem_valid || (cnt_q == LAST_MISS)) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    irv_d  = 1'b0;
    req_d  = (state_d == ST_WAIT);
    if (pc_rst) begin
      pc_d  = '0;
      ir_d  = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else begin
      case (state_q)
        // A fetch owns the PC increment, so a same-cycle pc_write loses.
        ST_IDLE: begin
          if (ir_load) begin
            addr_d = pc_q;
            cnt_d  = '0;
          end else if (pc_write) begin
            pc_d = pc_sel ? br_target : (pc_q + PC_W'(1));
          end
        end
        ST_WAIT: begin
          if (mem_valid) begin
            ir_d  = mem_rdata;
            pc_d  = addr_q + PC_W'(1);
            irv_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_MISS) err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      req_q  <= 1'b0;
      irv_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      irv_q  <= irv_d;
      err_q  <= err_d;
    end
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign mem_addr  = addr_q;
  assign mem_req   = req_q;
  assign ir_valid  = irv_q;
  assign fetch_err = err_q;
  assign busy      = (state_q == ST_WAIT);
  assign opcode    = ir_q[OPC_MSB:OPC_LSB];
  assign mm        = ir_q[MM_MSB:MM_LSB];
  assign imm       = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_pc_ir_fetch.sv
// Self-checking bench for pc_ir_fetch: directed scenarios plus randomized
// fetch/branch traffic against an architectural PC/IR model.
module tb_pc_ir_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_rst = 1'b0;
  logic        ir_load = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic        busy;
  logic        ir_valid;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] model_pc = '0;
  logic [31:0] model_ir = '0;

  pc_ir_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .pc_rst    (pc_rst),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .pc        (pc),
    .ir        (ir),
    .opcode    (opcode),
    .mm        (mm),
    .imm       (imm),
    .busy      (busy),
    .ir_valid  (ir_valid),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({pc, ir, mem_addr} !== 64'h0) begin
      failures++;
      $display("FAIL reset_regs pc=%h ir=%h addr=%h expected all 0", pc, ir, mem_addr);
    end
    checks++;
    if ({mem_req, busy, ir_valid, fetch_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags req/busy/irv/err=%b expected 0000",
               {mem_req, busy, ir_valid, fetch_err});
    end
    rst = 1'b0;
    model_pc = '0;
    model_ir = '0;
    tick();
  endtask

  // One fetch with 'delay' missed cycles; noise injects commands that must be ignored.
  task automatic run_fetch(input int delay, input logic [31:0] data, input bit noise);
    int busy_cnt;
    busy_cnt = 0;
    ir_load = 1'b1;
    if (noise) begin
      pc_write = 1'b1;
      pc_sel   = 1'($urandom);
      br_sel   = 1'($urandom);
    end
    tick();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      if (busy) busy_cnt++;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== model_pc) begin
        failures++;
        $display("FAIL fetch_wait cyc=%0d req=%b addr=%h expected req=1 addr=%h",
                 i, mem_req, mem_addr, model_pc);
      end
      if (i < delay) begin
        if (noise) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = 1'($urandom);
          ir_load  = 1'($urandom);
        end
        tick();
        pc_write = 1'b0;
        ir_load  = 1'b0;
      end
    end
    mem_valid = 1'b1;
    mem_rdata = data;
    tick();
    mem_valid = 1'b0;
    model_pc  = model_pc + 16'd1;
    model_ir  = data;
    checks++;
    if (pc !== model_pc || ir !== model_ir) begin
      failures++;
      $display("FAIL fetch_result pc=%h ir=%h expected pc=%h ir=%h", pc, ir, model_pc, model_ir);
    end
    checks++;
    if (ir_valid !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done irv=%b busy=%b req=%b expected 1 0 0", ir_valid, busy, mem_req);
    end
    checks++;
    if (opcode !== data[31:28] || mm !== data[27:24] || imm !== data[15:0]) begin
      failures++;
      $display("FAIL fetch_fields op=%h mm=%h imm=%h expected %h %h %h",
               opcode, mm, imm, data[31:28], data[27:24], data[15:0]);
    end
    checks++;
    if (busy_cnt != delay + 1) begin
      failures++;
      $display("FAIL fetch_busy_len got=%0d expected=%0d", busy_cnt, delay + 1);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL ir_valid_pulse got=%b expected 0", ir_valid);
    end
  endtask

  task automatic do_branch(input bit sel, input bit bs);
    int t;
    logic [15:0] im;
    im = model_ir[15:0];
    pc_write = 1'b1;
    pc_sel   = sel;
    br_sel   = bs;
    tick();
    pc_write = 1'b0;
    if (!sel) begin
      model_pc = model_pc + 16'd1;
    end else if (bs) begin
      model_pc = im;
    end else begin
      t = int'(model_pc) + int'($signed(im));
      model_pc = 16'(((t % 65536) + 65536) % 65536);
    end
    checks++;
    if (pc !== model_pc || busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL branch sel=%b br=%b imm=%h pc=%h busy=%b req=%b expected pc=%h",
               sel, bs, im, pc, busy, mem_req, model_pc);
    end
  endtask

  task automatic test_zero_wait();
    run_fetch(0, 32'h8123_0004, 1'b0);
    checks++;
    if (ir !== 32'h8123_0004 || opcode !== 4'h8 || mm !== 4'h1 || pc !== 16'h0001) begin
      failures++;
      $display("FAIL zero_wait ir=%h op=%h mm=%h pc=%h expected 81230004 8 1 0001",
               ir, opcode, mm, pc);
    end
  endtask

  task automatic test_delayed_fetch();
    logic [15:0] old_pc;
    old_pc = model_pc;
    run_fetch(3, 32'h1234_5678, 1'b1);
    checks++;
    if (pc !== old_pc + 16'd1) begin
      failures++;
      $display("FAIL delayed_pc got=%h expected=%h", pc, old_pc + 16'd1);
    end
  endtask

  task automatic test_branches();
    run_fetch(0, 32'h4000_000F, 1'b0);
    do_branch(1'b1, 1'b1);
    run_fetch(1, 32'h5000_FFFE, 1'b0);
    checks++;
    if (pc !== 16'h0010) begin
      failures++;
      $display("FAIL branch_setup pc=%h expected 0010", pc);
    end
    do_branch(1'b1, 1'b0);
    checks++;
    if (pc !== 16'h000E) begin
      failures++;
      $display("FAIL branch_rel_neg pc=%h expected 000E", pc);
    end
    run_fetch(0, 32'h4000_0040, 1'b0);
    do_branch(1'b1, 1'b1);
    checks++;
    if (pc !== 16'h0040) begin
      failures++;
      $display("FAIL branch_abs pc=%h expected 0040", pc);
    end
    run_fetch(0, 32'h4000_FFFE, 1'b0);
    do_branch(1'b1, 1'b1);
    run_fetch(2, 32'h5000_0002, 1'b0);
    do_branch(1'b1, 1'b0);
    checks++;
    if (pc !== 16'h0001) begin
      failures++;
      $display("FAIL branch_rel_wrap pc=%h expected 0001", pc);
    end
    do_branch(1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int req_cnt;
    bit addr_ok;
    req_cnt = 0;
    addr_ok = 1'b1;
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      req_cnt++;
      if (mem_addr !== model_pc) addr_ok = 1'b0;
      tick();
    end
    checks++;
    if (req_cnt != 15 || !addr_ok) begin
      failures++;
      $display("FAIL timeout_req_len got=%0d addr_ok=%0d expected 15 1", req_cnt, addr_ok);
    end
    checks++;
    if (fetch_err !== 1'b1 || busy !== 1'b0 || pc !== model_pc || ir !== model_ir) begin
      failures++;
      $display("FAIL timeout_state err=%b busy=%b pc=%h ir=%h expected 1 0 %h %h",
               fetch_err, busy, pc, ir, model_pc, model_ir);
    end
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_valid = 1'b0;
    checks++;
    if (ir !== model_ir || pc !== model_pc || ir_valid !== 1'b0 || fetch_err !== 1'b1) begin
      failures++;
      $display("FAIL late_valid ir=%h pc=%h irv=%b err=%b expected %h %h 0 1",
               ir, pc, ir_valid, fetch_err, model_ir, model_pc);
    end
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    model_pc = '0;
    model_ir = '0;
    checks++;
    if (fetch_err !== 1'b0 || pc !== 16'h0 || ir !== 32'h0) begin
      failures++;
      $display("FAIL pc_rst_clear err=%b pc=%h ir=%h expected 0 0 0", fetch_err, pc, ir);
    end
  endtask

  task automatic test_reset_collisions();
    run_fetch(0, 32'hA5A5_1234, 1'b0);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({pc, ir, mem_addr} !== 64'h0 || {mem_req, busy, ir_valid, fetch_err} !== 4'b0) begin
      failures++;
      $display("FAIL async_rst pc=%h ir=%h addr=%h flags=%b expected all 0",
               pc, ir, mem_addr, {mem_req, busy, ir_valid, fetch_err});
    end
    tick();
    rst = 1'b0;
    model_pc = '0;
    model_ir = '0;
    tick();
    run_fetch(1, 32'h3C3C_7777, 1'b0);
    ir_load = 1'b1;
    tick();
    ir_load   = 1'b0;
    pc_rst    = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    pc_rst    = 1'b0;
    mem_valid = 1'b0;
    model_pc  = '0;
    model_ir  = '0;
    checks++;
    if (ir !== 32'h0 || pc !== 16'h0 || ir_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pc_rst_vs_valid ir=%h pc=%h irv=%b req=%b busy=%b expected 0",
               ir, pc, ir_valid, mem_req, busy);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b0 || ir !== 32'h0) begin
      failures++;
      $display("FAIL pc_rst_late_pulse irv=%b ir=%h expected 0 0", ir_valid, ir);
    end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      if (op == 0) begin
        run_fetch(int'($urandom_range(0, 5)), $urandom, 1'($urandom));
      end else if (op == 1) begin
        do_branch(1'($urandom), 1'($urandom));
      end else if (op == 2) begin
        do_branch(1'b1, 1'b0);
      end else begin
        mem_valid = 1'b1;
        mem_rdata = $urandom;
        tick();
        mem_valid = 1'b0;
        checks++;
        if (ir !== model_ir || pc !== model_pc || ir_valid !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL idle_valid ir=%h pc=%h irv=%b busy=%b expected %h %h 0 0",
                   ir, pc, ir_valid, busy, model_ir, model_pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_fetch();
    test_branches();
    test_timeout();
    test_reset_collisions();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
